ir_receiver: RTL and testbench
==============================

IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 Parameter SYS_CLK_FREQ_HZ, default 100_000_000, system clock frequency (informational; tick math uses TICK_DIV).
REQ-002 Parameter TICK_DIV, default 2500, CLK cycles per measurement tick (25 us at 100 MHz).
REQ-003 Parameter CAR_COUNT, default 4, number of addressable cars.
REQ-004 Parameter CMD_LEN, default 4, command bits per packet.
REQ-005 Parameters START_MIN_TICKS 60, ONE_MIN_TICKS 20, CAR_UNIT_TICKS 8, TIMEOUT_TICKS 100: burst/space thresholds in ticks.
REQ-006 CLK  input  1  system clock; all state on rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset.
REQ-008 IR_IN  input  1  demodulated IR envelope, asynchronous, 1 = carrier present (mark).
REQ-009 RX_COMMAND  output  CMD_LEN  last decoded command, held until next valid packet.
REQ-010 RX_CAR  output  $clog2(CAR_COUNT)  last decoded car ID, held until next valid packet.
REQ-011 RX_VALID  output  1  one-cycle pulse: RX_COMMAND/RX_CAR updated this cycle.
REQ-012 RX_ERROR  output  1  one-cycle pulse: packet aborted.
REQ-013 RX_BUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 IR_IN SHALL pass a 2-flop synchronizer; edges are detected on the synchronized (optionally filtered) level "env".
REQ-015 Tick prescaler SHALL count 0..TICK_DIV-1, clear on every env edge, and emit a tick on wrap; length counter (8 bits, saturating at 255) SHALL clear on every env edge and increment per tick.
REQ-016 States: IDLE, START_MARK, SPACE, MARK; field index 0 = car burst, 1..CMD_LEN = data bursts.
REQ-017 IDLE: env rise -> START_MARK.
REQ-018 START_MARK: env fall with length >= START_MIN_TICKS -> SPACE, field=0; shorter -> IDLE, no error (noise).
REQ-019 SPACE: length reaching TIMEOUT_TICKS -> RX_ERROR pulse, IDLE; env rise -> MARK.
REQ-020 MARK, env fall, length >= START_MIN_TICKS in any field -> treat as new start: SPACE, field=0, partial data discarded, no error.
REQ-021 MARK field 0: k = length / CAR_UNIT_TICKS (compare/counter, no divider); k in 1..CAR_COUNT -> car = k-1, SPACE, field=1; else RX_ERROR, IDLE.
REQ-022 MARK field n>=1: bit n-1 = (length >= ONE_MIN_TICKS); if n < CMD_LEN -> SPACE, field n+1; if n = CMD_LEN -> IDLE.
REQ-023 On completion of field CMD_LEN, the cycle after the env fall is detected, RX_COMMAND/RX_CAR SHALL update and RX_VALID SHALL pulse for exactly one cycle.
REQ-024 Shadow registers SHALL collect car/bits; outputs SHALL never show a partial packet.
REQ-025 RX_VALID and RX_ERROR SHALL never assert in the same cycle; a new packet may start the cycle after RX_VALID.

Reset
REQ-026 RESET low SHALL immediately clear state to IDLE, counters, synchronizer and filter to 0, RX_COMMAND=0, RX_CAR=0, RX_VALID=0, RX_ERROR=0, RX_BUSY=0.
REQ-027 Reset mid-packet SHALL discard the packet with no RX_VALID or RX_ERROR; decoding resumes with the next start burst after release.

Configuration
REQ-028 Macro IR_RECEIVER_GLITCH_FILTER_EN defined: env SHALL change only after the synchronized input holds a new level for 4 consecutive CLK cycles (adds 4 cycles of edge latency; shorter pulses ignored).
REQ-029 Macro undefined: env SHALL equal the synchronizer output; no filtering.

Verification
REQ-030 Valid packet: start 80 ticks, space 10, car mark 20 ticks, data marks 30/5/30/5, spaces 10 -> one RX_VALID, RX_CAR=1, RX_COMMAND=4'b0101.
REQ-031 Timeout: start 80, car mark 8, then low 100 ticks -> one RX_ERROR, no RX_VALID, outputs unchanged, RX_BUSY low after.
REQ-032 Bad car: start 80, car mark 40 ticks (k=5 > CAR_COUNT) -> RX_ERROR, IDLE; following good packet decodes correctly.
REQ-033 Restart: valid start, car, two data bits, then 80-tick mark, then full packet car 0 cmd 4'b1111 -> single RX_VALID with RX_CAR=0, RX_COMMAND=4'b1111.
REQ-034 Reset mid-packet: RESET low during third data bit -> all outputs 0 immediately, no pulses; next packet decodes.
REQ-035 Glitch (macro defined): 2-cycle IR_IN pulses inserted in spaces of REQ-030 packet -> identical result; macro undefined -> RX_VALID absent or RX_ERROR/restart as state rules dictate.

Source files
------------

// File: rtl/ir_receiver.sv
// IR packet receiver: synchronizes the demodulated IR envelope, measures mark/space
// lengths in prescaled ticks and decodes start + car-ID burst + CMD_LEN data bursts.
// Optional feature: define IR_RECEIVER_GLITCH_FILTER_EN to add a 4-cycle level filter
// on the synchronized input (pulses shorter than 4 cycles never reach the decoder).
`timescale 1ns / 1ps

module ir_receiver #(
  parameter int unsigned SYS_CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_DIV        = 2500,
  parameter int unsigned CAR_COUNT       = 4,
  parameter int unsigned CMD_LEN         = 4,
  parameter int unsigned START_MIN_TICKS = 60,
  parameter int unsigned ONE_MIN_TICKS   = 20,
  parameter int unsigned CAR_UNIT_TICKS  = 8,
  parameter int unsigned TIMEOUT_TICKS   = 100,
  localparam int unsigned CarW = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IR_IN,
  output logic [CMD_LEN-1:0]  RX_COMMAND,
  output logic [CarW-1:0]     RX_CAR,
  output logic                RX_VALID,
  output logic                RX_ERROR,
  output logic                RX_BUSY
);

  // Clock frequency is informational only; a zero value falls back to a divide-by-1 tick.
  localparam int unsigned TickDiv = (SYS_CLK_FREQ_HZ > 0 && TICK_DIV > 0) ? TICK_DIV : 1;
  localparam int unsigned PresW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned FieldW  = $clog2(CMD_LEN + 1);

  localparam logic [PresW-1:0]  TickMax    = PresW'(TickDiv - 1);
  localparam logic [7:0]        StartMin   = 8'(START_MIN_TICKS);
  localparam logic [7:0]        OneMin     = 8'(ONE_MIN_TICKS);
  localparam logic [7:0]        TimeoutLen = 8'(TIMEOUT_TICKS);
  localparam logic [8:0]        CarMin     = 9'(CAR_UNIT_TICKS);
  localparam logic [8:0]        CarLim     = 9'((CAR_COUNT + 1) * CAR_UNIT_TICKS);
  localparam logic [FieldW-1:0] FieldLast  = FieldW'(CMD_LEN);

  typedef enum logic [1:0] {StIdle, StStartMark, StSpace, StMark} state_e;

  logic             sync1_q, sync2_q;
  logic             env, env_q;
  logic             env_rise, env_fall, env_edge;
  logic [PresW-1:0] pres_q, pres_d;
  logic [7:0]       len_q, len_d;
  logic             tick;

  state_e              state_q, state_d;
  logic [FieldW-1:0]   field_q, field_d;
  logic [CarW-1:0]     car_sh_q, car_sh_d;
  logic [CMD_LEN-1:0]  cmd_sh_q, cmd_sh_d;
  logic [CMD_LEN-1:0]  rx_cmd_q, rx_cmd_d;
  logic [CarW-1:0]     rx_car_q, rx_car_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [CarW-1:0]     car_k;
  logic                car_ok;
  logic                bit_one;
  logic [CMD_LEN-1:0]  cmd_next;

`ifdef IR_RECEIVER_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] filt_cnt_q, filt_cnt_d;

  // Accept a new level only after it has been seen on 4 consecutive cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == 2'd3) begin
        filt_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 2'd1;
      end
    end
  end

  // Filter state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign env = filt_q;
`else
  assign env = sync2_q;
`endif

  assign env_rise = env & ~env_q;
  assign env_fall = ~env & env_q;
  assign env_edge = env ^ env_q;

  // Prescaler and length counter restart on every envelope edge.
  always_comb begin
    tick   = (pres_q == TickMax);
    pres_d = pres_q + 1'b1;
    if (env_edge || tick) pres_d = '0;
    len_d = len_q;
    if (env_edge) begin
      len_d = '0;
    end else if (tick && len_q != 8'hFF) begin
      len_d = len_q + 8'd1;
    end
  end

  // Synchronizer, edge history and length measurement.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      env_q   <= 1'b0;
      pres_q  <= '0;
      len_q   <= '0;
    end else begin
      sync1_q <= IR_IN;
      sync2_q <= sync1_q;
      env_q   <= env;
      pres_q  <= pres_d;
      len_q   <= len_d;
    end
  end

  // Car index = floor(len / unit) - 1 via a comparator ladder; data bit at field position.
  always_comb begin
    car_k = '0;
    for (int unsigned i = 1; i < CAR_COUNT; i++) begin
      if ({1'b0, len_q} >= 9'((i + 1) * CAR_UNIT_TICKS)) car_k = CarW'(i);
    end
    car_ok  = ({1'b0, len_q} >= CarMin) && ({1'b0, len_q} < CarLim);
    bit_one = (len_q >= OneMin);
    cmd_next = cmd_sh_q;
    for (int unsigned i = 0; i < CMD_LEN; i++) begin
      if (field_q == FieldW'(i + 1)) cmd_next[i] = bit_one;
    end
  end

  // Packet decoder next state; outputs only change on a complete packet.
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    car_sh_d = car_sh_q;
    cmd_sh_d = cmd_sh_q;
    rx_cmd_d = rx_cmd_q;
    rx_car_d = rx_car_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (env_rise) state_d = StStartMark;
      end
      StStartMark: begin
        if (env_fall) begin
          if (len_q >= StartMin) begin
            state_d  = StSpace;
            field_d  = '0;
            cmd_sh_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StSpace: begin
        // Timeout wins over a simultaneous rise.
        if (len_q >= TimeoutLen) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (env_rise) begin
          state_d = StMark;
        end
      end
      StMark: begin
        if (env_fall) begin
          if (len_q >= StartMin) begin
            state_d  = StSpace;
            field_d  = '0;
            cmd_sh_d = '0;
          end else if (field_q == '0) begin
            if (car_ok) begin
              car_sh_d = car_k;
              field_d  = FieldW'(1);
              state_d  = StSpace;
            end else begin
              error_d = 1'b1;
              state_d = StIdle;
            end
          end else begin
            cmd_sh_d = cmd_next;
            if (field_q == FieldLast) begin
              rx_cmd_d = cmd_next;
              rx_car_d = car_sh_q;
              valid_d  = 1'b1;
              state_d  = StIdle;
            end else begin
              field_d = field_q + 1'b1;
              state_d = StSpace;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoder state, shadow and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      field_q  <= '0;
      car_sh_q <= '0;
      cmd_sh_q <= '0;
      rx_cmd_q <= '0;
      rx_car_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      car_sh_q <= car_sh_d;
      cmd_sh_q <= cmd_sh_d;
      rx_cmd_q <= rx_cmd_d;
      rx_car_q <= rx_car_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign RX_COMMAND = rx_cmd_q;
  assign RX_CAR     = rx_car_q;
  assign RX_VALID   = valid_q;
  assign RX_ERROR   = error_q;
  assign RX_BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_ir_receiver.sv
// Bench for ir_receiver: directed packets plus random burst sequences, decoded by a
// segment-level reference model (mark/space durations -> ticks -> packet rules).
`timescale 1ns / 1ps

module tb_ir_receiver;

  localparam int unsigned TD = 4;  // small tick divider keeps runs short
  localparam int EvErr = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ir_in;
  logic [3:0] rx_cmd;
  logic [1:0] rx_car;
  logic       rx_valid, rx_error, rx_busy;

  ir_receiver #(.TICK_DIV(TD)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .IR_IN     (ir_in),
    .RX_COMMAND(rx_cmd),
    .RX_CAR    (rx_car),
    .RX_VALID  (rx_valid),
    .RX_ERROR  (rx_error),
    .RX_BUSY   (rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int seg_lvl[$];
  int seg_cyc[$];
  int obs_q[$];
  int exp_q[$];
  int exp_car = 0;
  int exp_cmd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ev_valid(input int car, input int cmd);
    return 256 + car * 16 + cmd;
  endfunction

  // Cycles for an n-tick segment, centred between tick boundaries.
  function automatic int tk(input int n);
    return n * TD + TD / 2;
  endfunction

  task automatic add(input int lvl, input int cyc);
    seg_lvl.push_back(lvl);
    seg_cyc.push_back(cyc);
  endtask

  task automatic add_pkt(input int car, input int cmd);
    add(1, tk(80));
    add(0, tk(10));
    add(1, tk((car + 1) * 8 + 4));
    for (int b = 0; b < 4; b++) begin
      add(0, tk(10));
      add(1, tk(((cmd >> b) & 1) != 0 ? 30 : 5));
    end
  endtask

  task automatic glitch_space();
    add(0, 17);
    add(1, 2);
    add(0, 23);
  endtask

  // Reference: collapse the drive list into alternating levels, then apply packet rules.
  task automatic model_run();
    int lv[$];
    int cy[$];
    bit in_pkt = 0;
    int field = 0;
    int car = 0;
    int cmd = 0;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      int l = seg_lvl[i];
`ifdef IR_RECEIVER_GLITCH_FILTER_EN
      if (l == 1 && seg_cyc[i] < 4) l = 0;
`endif
      if (lv.size() > 0 && lv[lv.size()-1] == l) cy[cy.size()-1] += seg_cyc[i];
      else begin
        lv.push_back(l);
        cy.push_back(seg_cyc[i]);
      end
    end
    for (int i = 0; i < lv.size(); i++) begin
      int t = (cy[i] - 1) / int'(TD);
      if (t > 255) t = 255;
      if (lv[i] == 1) begin
        if (!in_pkt) begin
          if (t >= 60) begin
            in_pkt = 1;
            field = 0;
          end
        end else if (t >= 60) begin
          field = 0;
        end else if (field == 0) begin
          int k = t / 8;
          if (k >= 1 && k <= 4) begin
            car = k - 1;
            field = 1;
          end else begin
            exp_q.push_back(EvErr);
            in_pkt = 0;
          end
        end else begin
          cmd = (cmd & ~(1 << (field - 1))) | ((t >= 20 ? 1 : 0) << (field - 1));
          if (field == 4) begin
            exp_q.push_back(ev_valid(car, cmd));
            exp_car = car;
            exp_cmd = cmd;
            in_pkt = 0;
          end else begin
            field++;
          end
        end
      end else if (in_pkt && t >= 100) begin
        exp_q.push_back(EvErr);
        in_pkt = 0;
      end
    end
  endtask

  task automatic drive_segs();
    for (int i = 0; i < seg_lvl.size(); i++) begin
      ir_in = seg_lvl[i][0];
      repeat (seg_cyc[i]) @(negedge clk);
    end
  endtask

  task automatic run_seq(input string name);
    int n;
    add(0, tk(105));
    model_run();
    drive_segs();
    repeat (10) @(negedge clk);
    check({name, "_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", name, i), obs_q[i], exp_q[i]);
    check({name, "_car"}, rx_car, exp_car);
    check({name, "_cmd"}, rx_cmd, exp_cmd);
    check({name, "_busy"}, rx_busy, 0);
    obs_q.delete();
    exp_q.delete();
    seg_lvl.delete();
    seg_cyc.delete();
  endtask

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid === 1'b1) begin
        check("error_with_valid", rx_error, 0);
        obs_q.push_back(ev_valid(int'(rx_car), int'(rx_cmd)));
      end
      if (rx_error === 1'b1) obs_q.push_back(EvErr);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    ir_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd", rx_cmd, 0);
    check("rst_car", rx_car, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_error", rx_error, 0);
    check("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    add_pkt(1, 5);
    run_seq("valid");
    check("valid_car_const", rx_car, 1);
    check("valid_cmd_const", rx_cmd, 5);

    add(1, tk(80));
    add(0, tk(10));
    add(1, tk(8));
    run_seq("timeout");
    check("timeout_car_held", rx_car, 1);
    check("timeout_cmd_held", rx_cmd, 5);

    add(1, tk(80));
    add(0, tk(10));
    add(1, tk(40));
    add(0, tk(20));
    add_pkt(2, 10);
    run_seq("badcar");
    check("badcar_car_const", rx_car, 2);
    check("badcar_cmd_const", rx_cmd, 10);

    add(1, tk(80));
    add(0, tk(10));
    add(1, tk(20));
    add(0, tk(10));
    add(1, tk(30));
    add(0, tk(10));
    add(1, tk(5));
    add(0, tk(10));
    add_pkt(0, 15);
    run_seq("restart");
    check("restart_car_const", rx_car, 0);
    check("restart_cmd_const", rx_cmd, 15);

    // Reset asserted in the middle of the third data mark.
    add(1, tk(80));
    add(0, tk(10));
    add(1, tk(20));
    add(0, tk(10));
    add(1, tk(30));
    add(0, tk(10));
    add(1, tk(5));
    add(0, tk(10));
    add(1, tk(10));
    drive_segs();
    seg_lvl.delete();
    seg_cyc.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", rx_cmd, 0);
    check("midrst_car", rx_car, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_error", rx_error, 0);
    check("midrst_busy", rx_busy, 0);
    repeat (4) @(negedge clk);
    ir_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (tk(20)) @(negedge clk);
    check("midrst_no_pulse", obs_q.size(), 0);
    obs_q.delete();
    exp_car = 0;
    exp_cmd = 0;
    add_pkt(3, 6);
    run_seq("postrst");

    add(1, tk(80));
    glitch_space();
    add(1, tk(20));
    for (int b = 0; b < 4; b++) begin
      glitch_space();
      add(1, tk((b % 2 == 0) ? 30 : 5));
    end
    run_seq("glitch");
`ifdef IR_RECEIVER_GLITCH_FILTER_EN
    check("glitch_car_const", rx_car, 1);
    check("glitch_cmd_const", rx_cmd, 5);
`endif

    for (int it = 0; it < 20; it++) begin
      add(1, tk(($urandom_range(99) < 85) ? $urandom_range(60, 100) : $urandom_range(30, 59)));
      for (int f = 0; f < 5; f++) begin
        add(0, tk(($urandom_range(19) == 0) ? $urandom_range(100, 104) : $urandom_range(1, 30)));
        if (f == 0) add(1, tk($urandom_range(1, 45)));
        else if ($urandom_range(14) == 0) add(1, tk($urandom_range(60, 90)));
        else add(1, tk($urandom_range(1, 40)));
      end
      run_seq($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
